e203_exu_csr_arbt: RTL and testbench

- Shares the single CSR register-file access port between two requesters: the ALU CSR-instruction path (req 0) and the debug-module abstract-command path (req 1).
- Accepts one request at a time. Sequences it through a fixed grant → execute → respond FSM.
- Performs the read-modify-write (write/set/clear) against the CSR file and returns read data and an error flag to the winning requester.
- Sits between the EXU ALU/debug logic and the CSR register file.

---
 rtl/e203_exu_csr_arbt_pkg.sv | 25 ++
 rtl/e203_exu_csr_arbt_sel.sv | 19 +
 rtl/e203_exu_csr_arbt.sv | 169 ++++++++++++++++
 tb/tb_e203_exu_csr_arbt.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_exu_csr_arbt_pkg.sv
// Shared encodings for the CSR port arbiter: operation codes, FSM states
// and requester identities.
package e203_exu_csr_arbt_pkg;

    localparam int E203_XLEN = 32;

    typedef enum logic [1:0] {
        CSR_OP_RD  = 2'b00,
        CSR_OP_WR  = 2'b01,
        CSR_OP_SET = 2'b10,
        CSR_OP_CLR = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arbt_state_e;

    typedef enum logic {
        OWN_ALU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

endpackage

// File: rtl/e203_exu_csr_arbt_sel.sv
// Two-way winner selection: fixed debug priority or round-robin on a tie,
// using the identity of the previously granted requester.
module e203_exu_csr_arbt_sel #(
    parameter bit DBG_PRIO = 1'b1
) (
    input  logic alu_valid_i,
    input  logic dbg_valid_i,
    input  logic last_dbg_i,
    output logic grant_alu_o,
    output logic grant_dbg_o
);

    // Debug loses a tie only in round-robin mode when it won last time.
    always_comb begin
        grant_dbg_o = dbg_valid_i & (DBG_PRIO | ~alu_valid_i | ~last_dbg_i);
        grant_alu_o = alu_valid_i & ~grant_dbg_o;
    end

endmodule

// File: rtl/e203_exu_csr_arbt.sv
// CSR register-file port arbiter between the ALU CSR-instruction path and
// the debug abstract-command path. One access at a time, sequenced through
// IDLE -> EXEC -> RESP, performing the read-modify-write on the CSR file.
module e203_exu_csr_arbt
    import e203_exu_csr_arbt_pkg::*;
#(
    parameter int XLEN     = E203_XLEN,
    parameter bit DBG_PRIO = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            alu_req_valid,
    output logic            alu_req_ready,
    input  logic [11:0]     alu_req_idx,
    input  logic [1:0]      alu_req_op,
    input  logic [XLEN-1:0] alu_req_wdat,
    output logic            alu_rsp_valid,
    input  logic            alu_rsp_ready,
    output logic [XLEN-1:0] alu_rsp_rdat,
    output logic            alu_rsp_err,

    input  logic            dbg_req_valid,
    output logic            dbg_req_ready,
    input  logic [11:0]     dbg_req_idx,
    input  logic [1:0]      dbg_req_op,
    input  logic [XLEN-1:0] dbg_req_wdat,
    output logic            dbg_rsp_valid,
    input  logic            dbg_rsp_ready,
    output logic [XLEN-1:0] dbg_rsp_rdat,
    output logic            dbg_rsp_err,

    output logic            csr_ena,
    output logic            csr_rd_en,
    output logic            csr_wr_en,
    output logic [11:0]     csr_idx,
    output logic [XLEN-1:0] wbck_csr_dat,
    input  logic [XLEN-1:0] read_csr_dat,
    input  logic            csr_access_ilgl
);

    arbt_state_e     state_q, state_d;
    owner_e          owner_q, last_q;
    logic [11:0]     idx_q;
    csr_op_e         op_q;
    logic [XLEN-1:0] wdat_q;
    logic [XLEN-1:0] rdat_q;
    logic            err_q;

    logic grant_alu, grant_dbg;
    logic in_idle, in_exec, in_resp;
    logic req_hsk, owner_rsp_ready;

    e203_exu_csr_arbt_sel #(
        .DBG_PRIO (DBG_PRIO)
    ) u_sel (
        .alu_valid_i (alu_req_valid),
        .dbg_valid_i (dbg_req_valid),
        .last_dbg_i  (last_q == OWN_DBG),
        .grant_alu_o (grant_alu),
        .grant_dbg_o (grant_dbg)
    );

    assign in_idle = (state_q == ST_IDLE);
    assign in_exec = (state_q == ST_EXEC);
    assign in_resp = (state_q == ST_RESP);

    assign alu_req_ready   = in_idle & grant_alu;
    assign dbg_req_ready   = in_idle & grant_dbg;
    assign req_hsk         = alu_req_ready | dbg_req_ready;
    assign owner_rsp_ready = (owner_q == OWN_DBG) ? dbg_rsp_ready : alu_rsp_ready;

    // Next-state: grant -> single execute cycle -> hold response until taken.
    always_comb begin
        // NOTE: assigning a default before the case means every path drives
        // state_d, so no latch can be inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_hsk)         state_d = ST_EXEC;
            ST_EXEC:                      state_d = ST_RESP;
            ST_RESP: if (owner_rsp_ready) state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // State register and last-grant tracking (updated when the access executes).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            state_q <= ST_IDLE;
            last_q  <= OWN_ALU;
        end else begin
            state_q <= state_d;
            if (in_exec) last_q <= owner_q;
        end
    end

    // Latch the winning request on the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the request/response holding registers are reset as well;
            // they are few, and it keeps every output defined straight out of reset.
            owner_q <= OWN_ALU;
            idx_q   <= '0;
            op_q    <= CSR_OP_RD;
            wdat_q  <= '0;
        end else if (req_hsk) begin
            owner_q <= grant_dbg ? OWN_DBG : OWN_ALU;
            idx_q   <= grant_dbg ? dbg_req_idx : alu_req_idx;
            op_q    <= csr_op_e'(grant_dbg ? dbg_req_op : alu_req_op);
            wdat_q  <= grant_dbg ? dbg_req_wdat : alu_req_wdat;
        end
    end

    // Capture the old CSR value and error flag during the execute cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdat_q <= '0;
            err_q  <= 1'b0;
        end else if (in_exec) begin
            rdat_q <= csr_access_ilgl ? '0 : read_csr_dat;
            err_q  <= csr_access_ilgl;
        end
    end

    // CSR port drive: active only in EXEC, read-modify-write by operation.
    always_comb begin
        csr_ena      = 1'b0;
        csr_rd_en    = 1'b0;
        csr_wr_en    = 1'b0;
        csr_idx      = '0;
        wbck_csr_dat = '0;
        if (in_exec) begin
            csr_ena = 1'b1;
            csr_idx = idx_q;
            case (op_q)
                CSR_OP_RD: begin
                    csr_rd_en = 1'b1;
                end
                CSR_OP_WR: begin
                    csr_wr_en    = 1'b1;
                    wbck_csr_dat = wdat_q;
                end
                CSR_OP_SET: begin
                    csr_rd_en    = 1'b1;
                    csr_wr_en    = |wdat_q;
                    wbck_csr_dat = read_csr_dat | wdat_q;
                end
                CSR_OP_CLR: begin
                    csr_rd_en    = 1'b1;
                    csr_wr_en    = |wdat_q;
                    wbck_csr_dat = read_csr_dat & ~wdat_q;
                end
            endcase
        end
    end

    // Response to the owner only; data and error read as zero otherwise.
    always_comb begin
        alu_rsp_valid = in_resp & (owner_q == OWN_ALU);
        dbg_rsp_valid = in_resp & (owner_q == OWN_DBG);
        alu_rsp_rdat  = alu_rsp_valid ? rdat_q : '0;
        dbg_rsp_rdat  = dbg_rsp_valid ? rdat_q : '0;
        alu_rsp_err   = alu_rsp_valid & err_q;
        dbg_rsp_err   = dbg_rsp_valid & err_q;
    end

endmodule

// File: tb/tb_e203_exu_csr_arbt.sv
// Bench for the CSR port arbiter: one fixed-priority and one round-robin
// instance share stimulus; a transaction-level model checks both every cycle,
// and directed vectors pin hand-computed values.
module tb_e203_exu_csr_arbt;

    localparam int VW = 117;

    logic        clk, rst_n;
    logic        alu_req_valid, dbg_req_valid;
    logic [11:0] alu_req_idx, dbg_req_idx;
    logic [1:0]  alu_req_op, dbg_req_op;
    logic [31:0] alu_req_wdat, dbg_req_wdat;
    logic        alu_rsp_ready, dbg_rsp_ready;
    logic [31:0] read_csr_dat;
    logic        csr_access_ilgl;

    // fixed-priority instance outputs
    logic        p_alu_req_ready, p_dbg_req_ready, p_alu_rsp_valid, p_dbg_rsp_valid;
    logic [31:0] p_alu_rsp_rdat, p_dbg_rsp_rdat, p_wbck_csr_dat;
    logic        p_alu_rsp_err, p_dbg_rsp_err, p_csr_ena, p_csr_rd_en, p_csr_wr_en;
    logic [11:0] p_csr_idx;
    // round-robin instance outputs
    logic        r_alu_req_ready, r_dbg_req_ready, r_alu_rsp_valid, r_dbg_rsp_valid;
    logic [31:0] r_alu_rsp_rdat, r_dbg_rsp_rdat, r_wbck_csr_dat;
    logic        r_alu_rsp_err, r_dbg_rsp_err, r_csr_ena, r_csr_rd_en, r_csr_wr_en;
    logic [11:0] r_csr_idx;

    logic [VW-1:0] p_vec, r_vec;

    int n_total = 0;
    int n_bad   = 0;

    e203_exu_csr_arbt #(.XLEN(32), .DBG_PRIO(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .alu_req_valid(alu_req_valid), .alu_req_ready(p_alu_req_ready),
        .alu_req_idx(alu_req_idx), .alu_req_op(alu_req_op), .alu_req_wdat(alu_req_wdat),
        .alu_rsp_valid(p_alu_rsp_valid), .alu_rsp_ready(alu_rsp_ready),
        .alu_rsp_rdat(p_alu_rsp_rdat), .alu_rsp_err(p_alu_rsp_err),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(p_dbg_req_ready),
        .dbg_req_idx(dbg_req_idx), .dbg_req_op(dbg_req_op), .dbg_req_wdat(dbg_req_wdat),
        .dbg_rsp_valid(p_dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
        .dbg_rsp_rdat(p_dbg_rsp_rdat), .dbg_rsp_err(p_dbg_rsp_err),
        .csr_ena(p_csr_ena), .csr_rd_en(p_csr_rd_en), .csr_wr_en(p_csr_wr_en),
        .csr_idx(p_csr_idx), .wbck_csr_dat(p_wbck_csr_dat),
        .read_csr_dat(read_csr_dat), .csr_access_ilgl(csr_access_ilgl)
    );

    e203_exu_csr_arbt #(.XLEN(32), .DBG_PRIO(1'b0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .alu_req_valid(alu_req_valid), .alu_req_ready(r_alu_req_ready),
        .alu_req_idx(alu_req_idx), .alu_req_op(alu_req_op), .alu_req_wdat(alu_req_wdat),
        .alu_rsp_valid(r_alu_rsp_valid), .alu_rsp_ready(alu_rsp_ready),
        .alu_rsp_rdat(r_alu_rsp_rdat), .alu_rsp_err(r_alu_rsp_err),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(r_dbg_req_ready),
        .dbg_req_idx(dbg_req_idx), .dbg_req_op(dbg_req_op), .dbg_req_wdat(dbg_req_wdat),
        .dbg_rsp_valid(r_dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
        .dbg_rsp_rdat(r_dbg_rsp_rdat), .dbg_rsp_err(r_dbg_rsp_err),
        .csr_ena(r_csr_ena), .csr_rd_en(r_csr_rd_en), .csr_wr_en(r_csr_wr_en),
        .csr_idx(r_csr_idx), .wbck_csr_dat(r_wbck_csr_dat),
        .read_csr_dat(read_csr_dat), .csr_access_ilgl(csr_access_ilgl)
    );

    assign p_vec = {p_alu_req_ready, p_dbg_req_ready, p_alu_rsp_valid, p_alu_rsp_rdat,
                    p_alu_rsp_err, p_dbg_rsp_valid, p_dbg_rsp_rdat, p_dbg_rsp_err,
                    p_csr_ena, p_csr_rd_en, p_csr_wr_en, p_csr_idx, p_wbck_csr_dat};
    assign r_vec = {r_alu_req_ready, r_dbg_req_ready, r_alu_rsp_valid, r_alu_rsp_rdat,
                    r_alu_rsp_err, r_dbg_rsp_valid, r_dbg_rsp_rdat, r_dbg_rsp_err,
                    r_csr_ena, r_csr_rd_en, r_csr_wr_en, r_csr_idx, r_wbck_csr_dat};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Per instance k (0 = debug priority, 1 = round robin): how many cycles the
    // current access has progressed (0 idle, 1 on the CSR port, 2 answering),
    // the accepted request, the captured answer and who was served last.
    int          m_ph   [2];
    bit          m_dbg  [2];
    logic [11:0] m_idx  [2];
    logic [1:0]  m_op   [2];
    logic [31:0] m_wdat [2];
    logic [31:0] m_rdat [2];
    bit          m_err  [2];
    bit          m_last [2];

    // 0 = nobody, 1 = ALU, 2 = debug
    function automatic int pick(int k);
        if (alu_req_valid && dbg_req_valid) return (k == 0 || !m_last[k]) ? 2 : 1;
        if (dbg_req_valid) return 2;
        if (alu_req_valid) return 1;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_ph[k] = 0; m_dbg[k] = 0; m_last[k] = 0; m_err[k] = 0;
                m_idx[k] = '0; m_op[k] = '0; m_wdat[k] = '0; m_rdat[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_ph[k] == 0) begin
                    int w;
                    w = pick(k);
                    if (w != 0) begin
                        m_dbg[k]  = (w == 2);
                        m_idx[k]  = (w == 2) ? dbg_req_idx  : alu_req_idx;
                        m_op[k]   = (w == 2) ? dbg_req_op   : alu_req_op;
                        m_wdat[k] = (w == 2) ? dbg_req_wdat : alu_req_wdat;
                        m_ph[k]   = 1;
                    end
                end else if (m_ph[k] == 1) begin
                    m_err[k]  = csr_access_ilgl;
                    m_rdat[k] = csr_access_ilgl ? 32'h0 : read_csr_dat;
                    m_last[k] = m_dbg[k];
                    m_ph[k]   = 2;
                end else begin
                    if (m_dbg[k] ? dbg_rsp_ready : alu_rsp_ready) m_ph[k] = 0;
                end
            end
        end
    end

    function automatic logic [VW-1:0] model_out(int k);
        int          w;
        bit          ena, rd, wr, av, dv;
        logic [31:0] wb, ar, dr;
        logic [11:0] ix;
        w   = (m_ph[k] == 0) ? pick(k) : 0;
        ena = (m_ph[k] == 1);
        ix  = ena ? m_idx[k] : 12'h0;
        rd  = ena && (m_op[k] != 2'b01);
        wr  = ena && (m_op[k] == 2'b01 || (m_op[k] != 2'b00 && m_wdat[k] != 0));
        wb  = 32'h0;
        if (ena) begin
            case (m_op[k])
                2'b01:   wb = m_wdat[k];
                2'b10:   wb = read_csr_dat | m_wdat[k];
                2'b11:   wb = read_csr_dat & ~m_wdat[k];
                default: wb = 32'h0;
            endcase
        end
        av = (m_ph[k] == 2) && !m_dbg[k];
        dv = (m_ph[k] == 2) &&  m_dbg[k];
        ar = av ? m_rdat[k] : 32'h0;
        dr = dv ? m_rdat[k] : 32'h0;
        return {(w == 1), (w == 2), av, ar, av & m_err[k], dv, dr, dv & m_err[k],
                ena, rd, wr, ix, wb};
    endfunction

    // Compare process: every cycle out of reset, both instances.
    always @(negedge clk) begin
        if (rst_n) begin
            check("model_prio", p_vec, model_out(0));
            check("model_rr",   r_vec, model_out(1));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drop_req();
        alu_req_valid = 1'b0;
        dbg_req_valid = 1'b0;
    endtask

    task automatic run_txn(input string name, input bit is_dbg, input logic [11:0] idx,
                           input logic [1:0] op, input logic [31:0] wdat,
                           input logic [31:0] csr_val, input bit ilgl,
                           input bit exp_wr, input bit exp_rd, input logic [31:0] exp_wbck,
                           input logic [31:0] exp_rdat, input bit exp_err);
        bit got;
        @(posedge clk); #1;
        read_csr_dat    = csr_val;
        csr_access_ilgl = ilgl;
        if (is_dbg) begin
            dbg_req_valid = 1'b1; dbg_req_idx = idx; dbg_req_op = op; dbg_req_wdat = wdat;
        end else begin
            alu_req_valid = 1'b1; alu_req_idx = idx; alu_req_op = op; alu_req_wdat = wdat;
        end
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = is_dbg ? p_dbg_req_ready : p_alu_req_ready;
        end
        check({name, "_grant"}, got, 1);
        if (!got) begin
            drop_req();
            return;
        end
        @(posedge clk); #1;
        drop_req();
        @(negedge clk);
        check({name, "_exec"}, {p_csr_ena, p_csr_wr_en, p_csr_rd_en, p_csr_idx, p_wbck_csr_dat},
              {1'b1, exp_wr, exp_rd, idx, exp_wbck});
        @(negedge clk);
        if (is_dbg)
            check({name, "_rsp"}, {p_dbg_rsp_valid, p_dbg_rsp_rdat, p_dbg_rsp_err},
                  {1'b1, exp_rdat, exp_err});
        else
            check({name, "_rsp"}, {p_alu_rsp_valid, p_alu_rsp_rdat, p_alu_rsp_err},
                  {1'b1, exp_rdat, exp_err});
        @(negedge clk);
        check({name, "_done"}, {p_alu_rsp_valid, p_dbg_rsp_valid}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          got;
        logic [3:0]  rr_seq;
        int          rr_n, pd_n, pa_n;

        rst_n = 1'b0;
        drop_req();
        alu_req_idx = '0; alu_req_op = '0; alu_req_wdat = '0;
        dbg_req_idx = '0; dbg_req_op = '0; dbg_req_wdat = '0;
        alu_rsp_ready = 1'b1; dbg_rsp_ready = 1'b1;
        read_csr_dat = '0; csr_access_ilgl = 1'b0;

        #12;
        check("reset_prio", p_vec, '0);
        check("reset_rr",   r_vec, '0);
        #10 rst_n = 1'b1;

        // Single requester accesses.
        run_txn("alu_write", 0, 12'h340, 2'b01, 32'hDEAD_BEEF, 32'h1234, 0,
                1, 0, 32'hDEAD_BEEF, 32'h1234, 0);
        run_txn("alu_set",   0, 12'h300, 2'b10, 32'h8, 32'h3, 0, 1, 1, 32'hB, 32'h3, 0);
        run_txn("alu_clear", 0, 12'h300, 2'b11, 32'h1, 32'h3, 0, 1, 1, 32'h2, 32'h3, 0);
        run_txn("set_zero",  0, 12'h300, 2'b10, 32'h0, 32'h3, 0, 0, 1, 32'h3, 32'h3, 0);
        run_txn("dbg_read",  1, 12'h7B0, 2'b00, 32'h5A5A, 32'hCAFE, 0, 0, 1, 32'h0, 32'hCAFE, 0);
        run_txn("dbg_ilgl",  1, 12'hFFF, 2'b00, 32'h0, 32'hFFFF, 1, 0, 1, 32'h0, 32'h0, 1);
        run_txn("wr_ilgl",   0, 12'h123, 2'b01, 32'h55, 32'h77, 1, 1, 0, 32'h55, 32'h0, 1);

        // Response backpressure on the debug requester.
        @(posedge clk); #1;
        dbg_req_valid = 1'b1; dbg_req_idx = 12'h300; dbg_req_op = 2'b00; dbg_req_wdat = '0;
        dbg_rsp_ready = 1'b0; read_csr_dat = 32'h1800; csr_access_ilgl = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = p_dbg_req_ready;
        end
        check("bp_grant", got, 1);
        @(posedge clk); #1;
        dbg_req_valid = 1'b0;
        alu_req_valid = 1'b1; alu_req_op = 2'b00; alu_req_idx = 12'h301;
        @(negedge clk);
        @(negedge clk);
        check("bp_rsp", {p_dbg_rsp_valid, p_dbg_rsp_rdat, p_dbg_rsp_err}, {1'b1, 32'h1800, 1'b0});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            read_csr_dat = 32'h1111 * (i + 1);
            @(negedge clk);
            check("bp_hold", {p_dbg_rsp_valid, p_dbg_rsp_rdat, p_dbg_rsp_err},
                  {1'b1, 32'h1800, 1'b0});
            check("bp_no_ready", {p_alu_req_ready, p_dbg_req_ready}, 2'b00);
        end
        @(posedge clk); #1;
        dbg_rsp_ready = 1'b1;
        alu_req_valid = 1'b0;
        @(negedge clk);
        check("bp_last", p_dbg_rsp_valid, 1);
        @(negedge clk);
        check("bp_idle", {p_dbg_rsp_valid, p_alu_rsp_valid}, 2'b00);

        // Reset asserted during the execute cycle.
        @(posedge clk); #1;
        alu_req_valid = 1'b1; alu_req_idx = 12'h305; alu_req_op = 2'b01; alu_req_wdat = 32'h100;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = p_alu_req_ready;
        end
        check("rst_grant", got, 1);
        @(posedge clk); #1;
        drop_req();
        @(negedge clk);
        check("rst_exec_ena", p_csr_ena, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_prio", p_vec, '0);
        check("rst_mid_rr",   r_vec, '0);
        @(negedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_rsp", {p_alu_rsp_valid, p_dbg_rsp_valid, r_alu_rsp_valid, r_dbg_rsp_valid}, 4'b0);
        end

        // Simultaneous requests right after reset (last grant = ALU).
        @(posedge clk); #1;
        alu_req_valid = 1'b1; alu_req_idx = 12'h340; alu_req_op = 2'b00;
        dbg_req_valid = 1'b1; dbg_req_idx = 12'h7B1; dbg_req_op = 2'b00;
        read_csr_dat = 32'h42;
        rr_seq = '0; rr_n = 0; pd_n = 0; pa_n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (r_dbg_req_ready || r_alu_req_ready) begin
                rr_seq = {rr_seq[2:0], r_dbg_req_ready};
                rr_n++;
            end
            if (p_dbg_req_ready) pd_n++;
            if (p_alu_req_ready) pa_n++;
        end
        @(posedge clk); #1;
        drop_req();
        check("rr_order", rr_seq, 4'b1010);
        check("rr_count", rr_n, 4);
        check("prio_dbg_grants", pd_n, 4);
        check("prio_alu_ready", pa_n, 0);

        // Normal access once more after all of the above.
        run_txn("post_rst", 0, 12'h341, 2'b11, 32'hF0, 32'hFF, 0, 1, 1, 32'h0F, 32'hFF, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
